// File: rtl/ula_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith ops plus a WIDTH-iteration shift-add multiplier.
// Optional status flags (zero/neg/ovf) are enabled with the ULA_SEQ_FLAGS_EN macro.
//
// state | meaning
// IDLE  | waiting for an operand bundle, in_ready high
// BUSY  | multiply in progress, one shift-add iteration per cycle
// DONE  | result presented on s/cout with out_valid until consumed
module ula_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef ULA_SEQ_FLAGS_EN
    ,
    output logic             zero,
    output logic             neg,
    output logic             ovf
`endif
);

    localparam int IDXW = $clog2(WIDTH);
    localparam int MSB  = WIDTH - 1;
    localparam logic [IDXW-1:0] CNT_LAST = IDXW'(WIDTH - 1);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOT  = 4'd3;
    localparam logic [3:0] OP_EQ   = 4'd4;
    localparam logic [3:0] OP_ADD  = 4'd5;
    localparam logic [3:0] OP_MUX  = 4'd6;
    localparam logic [3:0] OP_SUB  = 4'd7;
    localparam logic [3:0] OP_PASS = 4'd8;
    localparam logic [3:0] OP_MUL  = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     s_q;
    logic                 cout_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [IDXW-1:0]      cnt_q;

    logic [WIDTH-1:0]     alu_s;
    logic                 alu_c;
    logic [WIDTH:0]       add_sum;
    logic [WIDTH:0]       sub_diff;
    logic [WIDTH:0]       mul_add;
    logic [2*WIDTH-1:0]   prod_d;

    always_comb begin
        add_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        sub_diff = {1'b0, a} - {1'b0, b};
        alu_s    = '0;
        alu_c    = 1'b0;
        case (op)
            OP_AND:  alu_s = a & b;
            OP_OR:   alu_s = a | b;
            OP_XOR:  alu_s = a ^ b;
            OP_NOT:  alu_s = ~a;
            OP_EQ:   alu_s = {{(WIDTH-1){1'b0}}, (a == b)};
            OP_ADD: begin
                alu_s = add_sum[WIDTH-1:0];
                alu_c = add_sum[WIDTH];
            end
            OP_MUX:  alu_s = {{(WIDTH-1){1'b0}}, a[b[IDXW-1:0]]};
            OP_SUB: begin
                alu_s = sub_diff[WIDTH-1:0];
                alu_c = ~sub_diff[WIDTH];
            end
            OP_PASS: alu_s = b;
            default: alu_s = '0;
        endcase
    end

`ifdef ULA_SEQ_FLAGS_EN
    logic alu_v;
    always_comb begin
        alu_v = 1'b0;
        if (op == OP_ADD)
            alu_v = (a[MSB] == b[MSB]) && (add_sum[MSB] != a[MSB]);
        else if (op == OP_SUB)
            alu_v = (a[MSB] != b[MSB]) && (sub_diff[MSB] != a[MSB]);
    end
`endif

    // Right-shifting product: upper half accumulates, lower half holds the remaining multiplier bits.
    always_comb begin
        mul_add = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_d  = {mul_add, prod_q[WIDTH-1:1]};
    end

`ifdef ULA_SEQ_FLAGS_EN
    logic zero_q, neg_q, ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            cout_q      <= 1'b0;
            prod_q      <= '0;
            mcand_q     <= '0;
            cnt_q       <= '0;
`ifdef ULA_SEQ_FLAGS_EN
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        if (op == OP_MUL) begin
                            state_q <= BUSY;
                            mcand_q <= a;
                            prod_q  <= {{WIDTH{1'b0}}, b};
                            cnt_q   <= '0;
                        end else begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            s_q         <= alu_s;
                            cout_q      <= alu_c;
`ifdef ULA_SEQ_FLAGS_EN
                            zero_q      <= (alu_s == '0);
                            neg_q       <= alu_s[MSB];
                            ovf_q       <= alu_v;
`endif
                        end
                    end
                end
                BUSY: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        s_q         <= prod_d[WIDTH-1:0];
                        cout_q      <= |prod_d[2*WIDTH-1:WIDTH];
`ifdef ULA_SEQ_FLAGS_EN
                        zero_q      <= (prod_d[WIDTH-1:0] == '0);
                        neg_q       <= prod_d[MSB];
                        ovf_q       <= 1'b0;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign cout      = cout_q;
`ifdef ULA_SEQ_FLAGS_EN
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: directed cases plus randomized ops against an arithmetic reference model.
module tb_ula_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
`ifdef ULA_SEQ_FLAGS_EN
    logic         zero, neg, ovf;
`endif

    ula_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout)
`ifdef ULA_SEQ_FLAGS_EN
        , .zero(zero), .neg(neg), .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         z;
        logic         n;
        logic         v;
        int           lat;
        int           acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   outstanding = 0;
    bit   seen_valid = 0;
    bit   late_flag = 0;
    bit   rand_ready = 0;

    function automatic exp_t model(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y, logic ci);
        exp_t e;
        int ux = x;
        int uy = y;
        int sx = $signed(x);
        int sy = $signed(y);
        int r = 0;
        int sr = 0;
        e.c = 0; e.v = 0; e.lat = 1; e.acc = 0;
        case (o)
            4'd0: r = ux & uy;
            4'd1: r = ux | uy;
            4'd2: r = ux ^ uy;
            4'd3: r = (2**W - 1) - ux;
            4'd4: r = (ux == uy) ? 1 : 0;
            4'd5: begin
                r = ux + uy + int'(ci);
                e.c = (r >= 2**W);
                sr = sx + sy + int'(ci);
                e.v = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1)));
            end
            4'd6: r = (ux >> (uy % W)) & 1;
            4'd7: begin
                r = ux - uy;
                e.c = (ux >= uy);
                sr = sx - sy;
                e.v = (sr > 2**(W-1) - 1) || (sr < -(2**(W-1)));
            end
            4'd8: r = uy;
            4'd9: begin
                r = ux * uy;
                e.c = (r >= 2**W);
                e.lat = W + 1;
            end
            default: r = 0;
        endcase
        e.s = r[W-1:0];
        e.z = (e.s == '0);
        e.n = e.s[W-1];
        return e;
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Protocol tracker: a bundle is outstanding from its accept edge to its result handshake edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) outstanding = 0;
        else begin
            if (out_valid && out_ready) outstanding = 0;
            if (in_valid && in_ready) outstanding = 1;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("in_ready", int'(in_ready), int'(!outstanding));
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out_valid actual=1 expected=0 cyc=%0d", cyc);
                end else begin
                    if (!seen_valid) begin
                        chk("latency", cyc - q[0].acc, q[0].lat);
                        seen_valid = 1;
                    end
                    chk("s", int'(s), int'(q[0].s));
                    chk("cout", int'(cout), int'(q[0].c));
`ifdef ULA_SEQ_FLAGS_EN
                    chk("zero", int'(zero), int'(q[0].z));
                    chk("neg", int'(neg), int'(q[0].n));
                    chk("ovf", int'(ovf), int'(q[0].v));
`endif
                    if (out_ready) begin
                        void'(q.pop_front());
                        seen_valid = 0;
                        late_flag = 0;
                    end
                end
            end else if (q.size() > 0 && outstanding && !late_flag && (cyc - q[0].acc > q[0].lat)) begin
                checks++;
                errors++;
                late_flag = 1;
                $display("FAIL late_result waited=%0d expected_latency=%0d", cyc - q[0].acc, q[0].lat);
            end
        end
    end

    // Called at posedge+1; holds in_valid until the DUT is ready, then the next edge accepts.
    task automatic send(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y, logic ci);
        exp_t e;
        int n = 0;
        op = o; a = x; b = y; cin = ci; in_valid = 1'b1;
        while (!in_ready) begin
            @(posedge clk); #1;
            n++;
            if (n > 500) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=0 expected=1");
                in_valid = 1'b0;
                return;
            end
        end
        e = model(o, x, y, ci);
        e.acc = cyc;
        q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 4'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout pending=%0d expected=0", q.size());
            q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s", int'(s), 0);
        chk("rst_cout", int'(cout), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
`ifdef ULA_SEQ_FLAGS_EN
        chk("rst_zero", int'(zero), 0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;

        send(4'd5, 8'hFF, 8'h01, 1'b0);
        send(4'd7, 8'h05, 8'h07, 1'b0);
        send(4'd7, 8'h80, 8'h01, 1'b0);
        send(4'd9, 8'h10, 8'h11, 1'b0);
        send(4'd9, 8'h0F, 8'h0F, 1'b0);
        send(4'd6, 8'b0010_0000, 8'hF5, 1'b0);
        send(4'd4, 8'h3C, 8'h3C, 1'b0);
        send(4'hC, 8'h5A, 8'hC3, 1'b1);
        send(4'd5, 8'hFF, 8'hFF, 1'b1);
        send(4'd9, 8'h00, 8'hA5, 1'b0);
        send(4'd3, 8'h96, 8'h00, 1'b0);
        drain();

        // Backpressure with a competing bundle held on the input.
        out_ready = 1'b0;
        send(4'd0, 8'hA5, 8'h3C, 1'b0);
        op = 4'd1; a = 8'h12; b = 8'h40; cin = 1'b0; in_valid = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        send(4'd1, 8'h12, 8'h40, 1'b0);
        drain();

        // Reset three cycles into a multiply.
        send(4'd9, 8'h37, 8'h5B, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        seen_valid = 0;
        late_flag = 0;
        @(negedge clk);
        chk("midmul_rst_out_valid", int'(out_valid), 0);
        chk("midmul_rst_in_ready", int'(in_ready), 1);
        chk("midmul_rst_s", int'(s), 0);
        chk("midmul_rst_cout", int'(cout), 0);
        @(posedge clk); #1;
        send(4'd5, 8'h01, 8'h02, 1'b1);
        drain();

        rand_ready = 1;
        for (int i = 0; i < 150; i++) begin
            logic [3:0] ro;
            n = int'($urandom_range(0, 3));
            repeat (n) begin @(posedge clk); #1; end
            ro = ($urandom_range(0, 4) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
            send(ro, W'($urandom), W'($urandom), 1'($urandom));
        end
        drain();
        rand_ready = 0;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
